// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and per-opcode flag write mask.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package alu_pkg;

  // Opcode encodings; any opcode with bit 3 set is illegal.
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_RED    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;

  // Bit positions inside the {N,V,Z} flag vector.
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Which architectural flag bits an opcode is allowed to overwrite.
  // Arithmetic ops load all three, logic/shift ops only Z, the rest none.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    if (!op[3]) begin
      case (op)
        OP_ADD, OP_SUB: begin
          m[FLAG_N] = 1'b1;
          m[FLAG_V] = 1'b1;
          m[FLAG_Z] = 1'b1;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          m[FLAG_Z] = 1'b1;
        end
        OP_RED, OP_PADDSB: begin
          m = 3'b000;
        end
        default: begin
          m = 3'b000;
        end
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two request ports, the ALU drive/return path, the response port and the flag view.
// Latency: none (wires only).
// Backpressure: req ports use valid/ready, response port uses valid/ready.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 2
);

  // Port 0: pipeline execute stage
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [ID_W-1:0]   req0_id;

  // Port 1: multi-op sequencer
  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [ID_W-1:0]   req1_id;

  // Shared ALU
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_flags;

  // Response buffer and architectural flags
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_port;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [2:0]        flags_q;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_id,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, req1_id,
    output req1_ready,
    output alu_in1, alu_in2, alu_op,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_port, rsp_id, rsp_data, rsp_err,
    input  rsp_ready,
    output flags_q
  );

  // Requester / ALU / consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_id,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, req1_id,
    input  req1_ready,
    input  alu_in1, alu_in2, alu_op,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_port, rsp_id, rsp_data, rsp_err,
    output rsp_ready,
    input  flags_q
  );

endinterface

// File: rtl/arb2_rr.sv
// Two-way round-robin arbiter (fixed priority to req[0] when ALU_ARB_FIXED_PRIO_EN is defined).
// Latency: combinational grant; pointer moves on the edge after an actual grant.
// Backpressure: en=0 forces gnt=0 and freezes the pointer.
module arb2_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Port 0 always wins; port 1 only gets the ALU when port 0 is idle.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  // No pointer state in this build, so the clock and reset have no load.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

`else

  // ptr_q names the port that wins the next contention; 0 after reset.
  logic ptr_q;
  logic ptr_d;

  // One-hot grant; on contention the port not granted most recently wins.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Hand priority to the other port after every real grant, hold otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 16-bit ALU between two requesters; owns the {N,V,Z} flag register (ALU_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: request accepted at edge T is presented on rsp_* right after T; one op per cycle sustained.
// Backpressure: a held response (rsp_valid & !rsp_ready) blocks both request ports; drain and refill share a cycle.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ID_W   = 2
) (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);

  logic              slot_free;
  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              grant_any;
  logic              sel1;
  logic [3:0]        sel_op;
  logic [ID_W-1:0]   sel_id;
  logic              sel_illegal;
  logic [2:0]        wr_mask;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_port_q,  rsp_port_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [2:0]        arch_flags_q, arch_flags_d;

  // The buffer can take a new op if empty or being drained this cycle.
  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign req_vec   = {bus.req1_valid, bus.req0_valid};

  arb2_rr u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_vec),
    .en  (slot_free),
    .gnt (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign grant_any      = gnt[0] | gnt[1];
  assign sel1           = gnt[1];

  // Steer the granted request onto the ALU; port 0 fields when idle.
  always_comb begin
    bus.alu_in1 = bus.req0_a;
    bus.alu_in2 = bus.req0_b;
    bus.alu_op  = bus.req0_op;
    sel_op      = bus.req0_op;
    sel_id      = bus.req0_id;
    if (sel1) begin
      bus.alu_in1 = bus.req1_a;
      bus.alu_in2 = bus.req1_b;
      bus.alu_op  = bus.req1_op;
      sel_op      = bus.req1_op;
      sel_id      = bus.req1_id;
    end
  end

  // Illegal opcodes are accepted but produce zero data and leave flags alone.
  assign sel_illegal = sel_op[3];
  assign wr_mask     = flag_mask(sel_op);

  // Next state of the response slot and flags: capture on grant, clear on drain, hold otherwise.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_port_d   = rsp_port_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    arch_flags_d = arch_flags_q;
    if (grant_any) begin
      rsp_valid_d  = 1'b1;
      rsp_port_d   = sel1;
      rsp_id_d     = sel_id;
      rsp_err_d    = sel_illegal;
      rsp_data_d   = sel_illegal ? '0 : bus.alu_out;
      arch_flags_d = (arch_flags_q & ~wr_mask) | (bus.alu_flags & wr_mask);
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Response buffer and flag register; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      arch_flags_q <= 3'b000;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      arch_flags_q <= arch_flags_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_port  = rsp_port_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.flags_q   = arch_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised + directed bench for alu_share_arbiter with a scoreboard and an ALU model.
// Latency: n/a.
// Backpressure: rsp_ready is randomly withheld.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(16), .ID_W(2)) bus ();

  alu_share_arbiter #(.DATA_W(16), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        port;
    logic [1:0]  id;
    logic [15:0] data;
    logic        err;
    logic [2:0]  flags;
  } exp_t;

  exp_t q[$];

  // model state
  logic       m_full;
  logic       m_last;
  logic [2:0] m_flags;

  // flag override lets the bench force flag patterns a real ALU cannot make
  logic       flag_ovr_en;
  logic [2:0] flag_ovr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural ALU: returns {N,V,Z,result}
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    logic signed [8:0] s;
    logic [3:0]  sh;
    r  = 16'd0;
    v  = 1'b0;
    s  = 9'sd0;
    sh = b[3:0];
    case (op[2:0])
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a ^ b;
      3'd3: r = {15'd0, ^a};
      3'd4: r = a << sh;
      3'd5: r = 16'($signed(a) >>> sh);
      3'd6: r = (a >> sh) | (a << (5'd16 - {1'b0, sh}));
      default: begin
        for (int k = 0; k < 2; k++) begin
          s = {a[8*k+7], a[8*k+:8]} + {b[8*k+7], b[8*k+:8]};
          if (s > 9'sd127)       r[8*k+:8] = 8'h7F;
          else if (s < -9'sd128) r[8*k+:8] = 8'h80;
          else                   r[8*k+:8] = s[7:0];
        end
      end
    endcase
    return {r[15], v, (r == 16'd0), r};
  endfunction

  // Flag write rule by opcode
  function automatic logic [2:0] exp_mask(input logic [3:0] op);
    if (op[3]) return 3'b000;
    case (op)
      4'd0, 4'd1:             return 3'b111;
      4'd2, 4'd4, 4'd5, 4'd6: return 3'b001;
      default:                return 3'b000;
    endcase
  endfunction

  // external ALU
  logic [18:0] alu_res;
  always_comb begin
    alu_res       = alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2);
    bus.alu_out   = alu_res[15:0];
    bus.alu_flags = flag_ovr_en ? flag_ovr : alu_res[18:16];
  end

  // Reference model: predicts grants and pushes expected responses
  always @(negedge clk) begin : model
    logic sf, g0, g1;
    logic [3:0] op;
    logic [15:0] a, b;
    logic [1:0] id;
    logic [18:0] res;
    logic [2:0] f, mk;
    exp_t e;
    if (rst) begin
      m_full  = 1'b0;
      m_last  = 1'b1;
      m_flags = 3'b000;
      q.delete();
    end else begin
      sf = !m_full || bus.rsp_ready;
      g0 = 1'b0;
      g1 = 1'b0;
      if (sf) begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          g0 = 1'b1;
`else
          if (m_last) g0 = 1'b1;
          else        g1 = 1'b1;
`endif
        end else if (bus.req0_valid) begin
          g0 = 1'b1;
        end else if (bus.req1_valid) begin
          g1 = 1'b1;
        end
      end
      check("req0_ready", 32'(bus.req0_ready), 32'(g0));
      check("req1_ready", 32'(bus.req1_ready), 32'(g1));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
      if (g0 || g1) begin
        op  = g1 ? bus.req1_op : bus.req0_op;
        a   = g1 ? bus.req1_a  : bus.req0_a;
        b   = g1 ? bus.req1_b  : bus.req0_b;
        id  = g1 ? bus.req1_id : bus.req0_id;
        res = alu_fn(op, a, b);
        f   = flag_ovr_en ? flag_ovr : res[18:16];
        mk  = exp_mask(op);
        m_flags = (m_flags & ~mk) | (f & mk);
        e.port  = g1;
        e.id    = id;
        e.err   = op[3];
        e.data  = op[3] ? 16'd0 : res[15:0];
        e.flags = m_flags;
        q.push_back(e);
        m_full = 1'b1;
        m_last = g1;
      end else if (bus.rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: pops on every accepted response and compares
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got response with empty scoreboard, required none");
      end else begin
        e = q.pop_front();
        check("rsp_port",  32'(bus.rsp_port), 32'(e.port));
        check("rsp_id",    32'(bus.rsp_id),   32'(e.id));
        check("rsp_data",  32'(bus.rsp_data), 32'(e.data));
        check("rsp_err",   32'(bus.rsp_err),  32'(e.err));
        check("rsp_flags", 32'(bus.flags_q),  32'(e.flags));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic set_port(input logic p, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] id);
    if (p) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_id = id;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_id = id;
    end
  endtask

  task automatic issue_one(input logic p, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] id);
    set_port(p, op, a, b, id);
    bus.req0_valid = !p;
    bus.req1_valid = p;
    cyc();
    idle();
  endtask

  initial begin
    logic exp_g1;
    rst = 1'b1;
    flag_ovr_en = 1'b0;
    flag_ovr = 3'b000;
    idle();
    set_port(1'b0, 4'd0, 16'd0, 16'd0, 2'd0);
    set_port(1'b1, 4'd0, 16'd0, 16'd0, 2'd0);
    bus.rsp_ready = 1'b1;

    #12;
    check("rst_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_port",  32'(bus.rsp_port),  32'h0);
    check("rst_id",    32'(bus.rsp_id),    32'h0);
    check("rst_data",  32'(bus.rsp_data),  32'h0);
    check("rst_err",   32'(bus.rsp_err),   32'h0);
    check("rst_flags", 32'(bus.flags_q),   32'h0);
    cyc();
    rst = 1'b0;

    // contention: alternate after reset, port 0 first
    set_port(1'b0, 4'd2, 16'h1234, 16'h00FF, 2'd1);
    set_port(1'b1, 4'd3, 16'h0F0F, 16'h0001, 2'd3);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g1 = 1'b0;
`else
      exp_g1 = (i % 2) == 1;
`endif
      check("alt_gnt1", 32'(bus.req1_ready), 32'(exp_g1));
      cyc();
    end
    idle();
    cyc();

    // single ADD overflow
    issue_one(1'b0, 4'd0, 16'h7FFF, 16'h0001, 2'd1);
    check("add_valid", 32'(bus.rsp_valid), 32'h1);
    check("add_port",  32'(bus.rsp_port),  32'h0);
    check("add_data",  32'(bus.rsp_data),  32'h8000);
    check("add_flags", 32'(bus.flags_q),   32'h6);

    // flag masking
    issue_one(1'b0, 4'd1, 16'd5, 16'd5, 2'd0);
    check("sub_flags", 32'(bus.flags_q), 32'h1);
    issue_one(1'b1, 4'd0, 16'h8000, 16'h8000, 2'd2);
    check("add2_flags", 32'(bus.flags_q), 32'h3);
    issue_one(1'b0, 4'd2, 16'h00F0, 16'h0000, 2'd1);
    check("xor_flags", 32'(bus.flags_q), 32'h2);
    issue_one(1'b1, 4'd7, 16'h7F80, 16'h0180, 2'd0);
    check("paddsb_flags", 32'(bus.flags_q), 32'h2);
    check("paddsb_data",  32'(bus.rsp_data), 32'h7F80);

    // illegal op
    issue_one(1'b1, 4'hA, 16'h1111, 16'h2222, 2'd2);
    check("ill_err",   32'(bus.rsp_err),  32'h1);
    check("ill_data",  32'(bus.rsp_data), 32'h0);
    check("ill_id",    32'(bus.rsp_id),   32'h2);
    check("ill_port",  32'(bus.rsp_port), 32'h1);
    check("ill_flags", 32'(bus.flags_q),  32'h2);

    // backpressure with both ports waiting
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("bp_rdy0", 32'(bus.req0_ready), 32'h0);
      check("bp_rdy1", 32'(bus.req1_ready), 32'h0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #3;
    check("bp_refill_gnt", 32'(bus.req0_ready | bus.req1_ready), 32'h1);
    cyc();
    check("bp_refill_valid", 32'(bus.rsp_valid), 32'h1);
    idle();
    cyc();

    // reset while a response is pending and flags are all set
    flag_ovr_en = 1'b1;
    flag_ovr    = 3'b111;
    issue_one(1'b0, 4'd0, 16'h0001, 16'h0002, 2'd3);
    check("pre_rst_flags", 32'(bus.flags_q), 32'h7);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.rsp_valid), 32'h0);
    check("arst_flags", 32'(bus.flags_q),   32'h0);
    check("arst_data",  32'(bus.rsp_data),  32'h0);
    cyc();
    rst = 1'b0;
    flag_ovr_en = 1'b0;
    #3;
    check("post_rst_gnt0", 32'(bus.req0_ready), 32'h1);
    cyc();
    idle();
    cyc();

    // randomised traffic
    for (int i = 0; i < 800; i++) begin
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      set_port(1'b0, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
               16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      set_port(1'b1, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
               16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // drain
    idle();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("drain_empty", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
